// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller: segment bit
// positions, hex glyphs, the digit entry type and the slot phase encoding.
package seg_scan_pkg;

  // Bit positions inside an active-high {dp,g,f,e,d,c,b,a} pattern.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Pin level that turns every segment off (pins are active-low).
  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  // Build a g..a glyph from the individual segments that should light.
  function automatic logic [6:0] glyph(input logic a, input logic b, input logic c,
                                       input logic d, input logic e, input logic f,
                                       input logic g);
    logic [6:0] m;
    m        = '0;
    m[SEG_A] = a;
    m[SEG_B] = b;
    m[SEG_C] = c;
    m[SEG_D] = d;
    m[SEG_E] = e;
    m[SEG_F] = f;
    m[SEG_G] = g;
    return m;
  endfunction

  localparam logic [6:0] GLYPH_0 = glyph(1, 1, 1, 1, 1, 1, 0);
  localparam logic [6:0] GLYPH_1 = glyph(0, 1, 1, 0, 0, 0, 0);
  localparam logic [6:0] GLYPH_2 = glyph(1, 1, 0, 1, 1, 0, 1);
  localparam logic [6:0] GLYPH_3 = glyph(1, 1, 1, 1, 0, 0, 1);
  localparam logic [6:0] GLYPH_4 = glyph(0, 1, 1, 0, 0, 1, 1);
  localparam logic [6:0] GLYPH_5 = glyph(1, 0, 1, 1, 0, 1, 1);
  localparam logic [6:0] GLYPH_6 = glyph(1, 0, 1, 1, 1, 1, 1);
  localparam logic [6:0] GLYPH_7 = glyph(1, 1, 1, 0, 0, 0, 0);
  localparam logic [6:0] GLYPH_8 = glyph(1, 1, 1, 1, 1, 1, 1);
  localparam logic [6:0] GLYPH_9 = glyph(1, 1, 1, 1, 0, 1, 1);
  localparam logic [6:0] GLYPH_A = glyph(1, 1, 1, 0, 1, 1, 1);
  localparam logic [6:0] GLYPH_B = glyph(0, 0, 1, 1, 1, 1, 1);
  localparam logic [6:0] GLYPH_C = glyph(1, 0, 0, 1, 1, 1, 0);
  localparam logic [6:0] GLYPH_D = glyph(0, 1, 1, 1, 1, 0, 1);
  localparam logic [6:0] GLYPH_E = glyph(1, 0, 0, 1, 1, 1, 1);
  localparam logic [6:0] GLYPH_F = glyph(1, 0, 0, 0, 1, 1, 1);

  // One digit register: raw=1 shows data as-is, raw=0 hex-decodes data[3:0]
  // with data[7] as the decimal point.
  typedef struct packed {
    logic       raw;
    logic [7:0] data;
  } digit_entry_t;

  localparam digit_entry_t ENTRY_BLANK = '{raw: 1'b1, data: 8'h00};

  // Where the scan sits inside the current digit slot.
  typedef enum logic [1:0] {
    PH_BLANK,
    PH_ON,
    PH_OFF
  } slot_phase_t;

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-high {dp,g..a} segment pattern.
module hex_to_seg
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  // Glyph lookup; the decimal point passes straight through.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    seg         = '0;
    seg[SEG_DP] = dp;
    case (nibble)
      4'h0: seg[6:0] = GLYPH_0;
      4'h1: seg[6:0] = GLYPH_1;
      4'h2: seg[6:0] = GLYPH_2;
      4'h3: seg[6:0] = GLYPH_3;
      4'h4: seg[6:0] = GLYPH_4;
      4'h5: seg[6:0] = GLYPH_5;
      4'h6: seg[6:0] = GLYPH_6;
      4'h7: seg[6:0] = GLYPH_7;
      4'h8: seg[6:0] = GLYPH_8;
      4'h9: seg[6:0] = GLYPH_9;
      4'hA: seg[6:0] = GLYPH_A;
      4'hB: seg[6:0] = GLYPH_B;
      4'hC: seg[6:0] = GLYPH_C;
      4'hD: seg[6:0] = GLYPH_D;
      4'hE: seg[6:0] = GLYPH_E;
      default: seg[6:0] = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Digit writes land in a shadow set that is copied to the active set once per
// frame, so a frame is never drawn from a half-updated set of digits.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [7:0]            wr_data,
  input  logic                  wr_raw,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [3:0]            brightness,
  output logic [7:0]            seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [2:0]            cur_digit,
  output logic                  frame_start
);

  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  // Lit cycles contributed by each brightness step.
  localparam int LIT_STEP = (PRESCALE - BLANK_CYCLES) / 16;

  digit_entry_t          shadow [NUM_DIGITS];
  digit_entry_t          active [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] act_en;
  logic [3:0]            act_bright;

  logic [CNT_W-1:0]      slot_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic                  slot_wrap;
  logic                  commit;

  slot_phase_t           phase;
  int                    lit_end;
  digit_entry_t          cur_entry;
  logic [7:0]            hex_pat;
  logic [7:0]            pattern;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign slot_wrap = (slot_cnt == CNT_W'(PRESCALE - 1));
  assign commit    = (digit_idx == '0) && (slot_cnt == '0);

  // Slot counter and digit index; the index advances when the slot wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt  <= '0;
      digit_idx <= '0;
    end else if (slot_wrap) begin
      slot_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      slot_cnt  <= slot_cnt + 1'b1;
    end
  end

  // Shadow writes and the once-per-frame copy into the active set.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the digit registers are reset explicitly because reset must blank
      // the display; that is only affordable since the file is a few entries.
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= ENTRY_BLANK;
        active[i] <= ENTRY_BLANK;
      end
      act_en     <= '0;
      act_bright <= '0;
    end else begin
      // NOTE: non-blocking assignments make the commit copy the pre-edge
      // shadow, so a write on the commit cycle waits for the next frame.
      if (commit) begin
        active     <= shadow;
        act_en     <= digit_en;
        act_bright <= brightness;
      end
      if (wr_en && (32'(wr_addr) < NUM_DIGITS)) begin
        shadow[wr_addr[IDX_W-1:0]] <= '{raw: wr_raw, data: wr_data};
      end
    end
  end

  // Classify the current slot position into blank / on / off.
  always_comb begin
    lit_end = BLANK_CYCLES + (32'(act_bright) + 1) * LIT_STEP;
    if (32'(slot_cnt) < BLANK_CYCLES) begin
      phase = PH_BLANK;
    end else if (32'(slot_cnt) < lit_end) begin
      phase = PH_ON;
    end else begin
      phase = PH_OFF;
    end
  end

  assign cur_entry = active[digit_idx];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_entry.data[3:0]),
    .dp     (cur_entry.data[SEG_DP]),
    .seg    (hex_pat)
  );

  // Pick the pattern for the current digit and decide what the pins show.
  always_comb begin
    pattern  = cur_entry.raw ? cur_entry.data : hex_pat;
    seg_next = SEG_ALL_OFF;
    an_next  = '1;
    if ((phase == PH_ON) && act_en[digit_idx]) begin
      an_next  = ~(NUM_DIGITS'(1) << digit_idx);
      seg_next = ~pattern;
    end
  end

  // Registered pin drivers, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_n       <= SEG_ALL_OFF;
      an_n        <= '1;
      cur_digit   <= '0;
      frame_start <= 1'b0;
    end else begin
      seg_n       <= seg_next;
      an_n        <= an_next;
      cur_digit   <= 3'(digit_idx);
      frame_start <= commit;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: a frame-position reference model
// predicts every output on every cycle, plus per-slot lit-cycle counts.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int PS    = 40;
  localparam int BC    = 8;
  localparam int W     = PS - BC;
  localparam int FRAME = ND * PS;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [7:0]    wr_data;
  logic          wr_raw;
  logic [ND-1:0] digit_en;
  logic [3:0]    brightness;
  logic [7:0]    seg_n;
  logic [ND-1:0] an_n;
  logic [2:0]    cur_digit;
  logic          frame_start;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_raw      (wr_raw),
    .digit_en    (digit_en),
    .brightness  (brightness),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .cur_digit   (cur_digit),
    .frame_start (frame_start)
  );

  // Standard hex glyphs, active-high g..a.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state: entries are {raw, data}.
  logic [8:0]    sh_m  [ND];
  logic [8:0]    act_m [ND];
  logic [ND-1:0] act_en_m;
  logic [3:0]    act_b_m;
  int            pos;          // frame position at the next clock edge
  int            cycle;
  int            lit_cnt [8];

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [7:0] ref_pattern(input logic [8:0] e);
    if (e[8]) return e[7:0];
    return {e[7], hex_tab[e[3:0]]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  // One clock: update the model from the sampled inputs, then check the pins.
  task automatic tick();
    int         d;
    int         off;
    logic       lit;
    logic [7:0] exp_seg;
    logic [3:0] exp_an;
    logic [2:0] exp_cur;
    logic       exp_fs;
    @(posedge clk);
    cycle++;
    if (reset) begin
      for (int i = 0; i < ND; i++) begin
        sh_m[i]  = 9'h100;
        act_m[i] = 9'h100;
      end
      act_en_m = '0;
      act_b_m  = '0;
      exp_seg  = 8'hFF;
      exp_an   = 4'hF;
      exp_cur  = 3'd0;
      exp_fs   = 1'b0;
      pos      = 0;
    end else begin
      d       = pos / PS;
      off     = pos % PS;
      lit     = (off >= BC) && (off < BC + (int'(act_b_m) + 1) * W / 16) && act_en_m[d];
      exp_an  = lit ? ~(4'b0001 << d) : 4'hF;
      exp_seg = lit ? ~ref_pattern(act_m[d]) : 8'hFF;
      exp_cur = 3'(d);
      exp_fs  = (pos == 0);
      if (pos == 0) begin
        for (int i = 0; i < ND; i++) act_m[i] = sh_m[i];
        act_en_m = digit_en;
        act_b_m  = brightness;
      end
      if (wr_en && wr_addr < 3'(ND)) sh_m[wr_addr] = {wr_raw, wr_data};
      pos = (pos + 1) % FRAME;
    end
    #1;
    chk("seg_n", 32'(seg_n), 32'(exp_seg));
    chk("an_n", 32'(an_n), 32'(exp_an));
    chk("cur_digit", 32'(cur_digit), 32'(exp_cur));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    if (an_n !== 4'hF && !$isunknown(cur_digit)) lit_cnt[cur_digit]++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the next edge is the commit edge.
  task automatic align();
    for (int i = 0; i < FRAME && pos != 0; i++) tick();
  endtask

  // Measure one full frame and compare lit cycles per slot with the
  // duty formula applied to the given brightness and enable mask.
  task automatic measure_frame(input logic [3:0] b, input logic [ND-1:0] en);
    align();
    for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
    run(FRAME);
    for (int i = 0; i < ND; i++)
      chk($sformatf("lit_cycles_d%0d", i), 32'(lit_cnt[i]),
          en[i] ? 32'((int'(b) + 1) * W / 16) : 32'd0);
  endtask

  initial begin
    cycle      = 0;
    pos        = 0;
    reset      = 1'b1;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_raw     = 1'b0;
    digit_en   = '0;
    brightness = '0;

    // Reset for 3 cycles, then two dark frames with periodic frame_start.
    run(3);
    reset = 1'b0;
    run(2 * FRAME);

    // Hex writes mid-frame; they show only from the next frame on.
    run(50);
    digit_en   = 4'hF;
    brightness = 4'd15;
    wr_en   = 1'b1; wr_raw = 1'b0;
    wr_addr = 3'd1; wr_data = 8'h03; tick();
    wr_addr = 3'd0; wr_data = 8'h80; tick();
    wr_en   = 1'b0;
    measure_frame(4'd15, 4'hF);

    // Brightness sweep, two frames each.
    brightness = 4'd7;
    measure_frame(4'd7, 4'hF);
    measure_frame(4'd7, 4'hF);
    brightness = 4'd0;
    measure_frame(4'd0, 4'hF);
    measure_frame(4'd0, 4'hF);

    // Raw write plus a disabled digit that keeps its slot.
    brightness = 4'd15;
    wr_en = 1'b1; wr_raw = 1'b1; wr_addr = 3'd2; wr_data = 8'h80; tick();
    wr_en = 1'b0;
    digit_en = 4'b1011;
    measure_frame(4'd15, 4'b1011);

    // Write landing exactly on the commit edge, then an out-of-range write.
    digit_en = 4'hF;
    align();
    wr_en = 1'b1; wr_raw = 1'b0; wr_addr = 3'd0; wr_data = 8'h05; tick();
    wr_en = 1'b0;
    run(2 * FRAME);
    run(17);
    wr_en = 1'b1; wr_raw = 1'b1; wr_addr = 3'd5; wr_data = 8'h5A; tick();
    wr_en = 1'b0;
    run(2 * FRAME);

    // Randomized writes, enables and brightness.
    for (int i = 0; i < 800; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      wr_raw  = 1'($urandom);
      if (i % 97 == 0) begin
        digit_en   = 4'($urandom);
        brightness = 4'($urandom);
      end
      tick();
    end
    wr_en = 1'b0;

    // Reset pulse during digit 2's ON phase; everything reads blank after.
    digit_en   = 4'hF;
    brightness = 4'd15;
    run(2 * FRAME);
    for (int i = 0; i < FRAME && pos != 2 * PS + 12; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(2 * FRAME);
    measure_frame(4'd15, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Owns the digit registers, which the CPU-side bus writes.
- Sequences digit selection with a programmable slot length, an anti-ghosting blank interval and 16-level brightness.
- Drives the registered, active-low segment and anode pins directly. It supersedes the two-digit alternate-every-cycle scheme.

Parameters:
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- PRESCALE, 1024: clocks per digit slot.
- BLANK_CYCLES, 16: clocks at slot start with all anodes and segments off. Must satisfy BLANK_CYCLES < PRESCALE, and (PRESCALE-BLANK_CYCLES) must be a multiple of 16.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe; single cycle, always accepted, no stall
- wr_addr  in  3  target digit index
- wr_data  in  8  raw mode: active-high {dp,g,f,e,d,c,b,a}; hex mode: [3:0] nibble, [7] dp
- wr_raw  in  1  1 = raw pattern, 0 = hex-decode
- digit_en  in  NUM_DIGITS  per-digit enable mask
- brightness  in  4  duty level 0..15
- seg_n  out  8  active-low {dp,g,f,e,d,c,b,a}
- an_n  out  NUM_DIGITS  active-low anode select, one-hot-low or all-high
- cur_digit  out  3  digit currently driven
- frame_start  out  1  one-cycle pulse per frame

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: seg_n=all 1, an_n=all 1, cur_digit=0, frame_start=0.
  - Internal state: slot_cnt=0, digit_idx=0.
  - Shadow and active digit entries = {raw=1, data=0x00}, i.e. blank.
  - Active digit_en and brightness = 0.
  - A reset asserted mid-scan forces all of the above on the next edge; the display goes dark immediately.
- Writes:
  - A write lands in the shadow entry[wr_addr] at the edge.
  - A write with wr_addr >= NUM_DIGITS is ignored.
  - Back-to-back writes to the same address: last one wins.
- Commit:
  - Occurs at the edge where digit_idx=0 and slot_cnt=0.
  - Copies all shadow entries, digit_en and brightness into the active set. This prevents tearing mid-frame.
  - A write in the same cycle as the commit is NOT visible this frame; it lands in the shadow and commits next frame.
- Counters:
  - slot_cnt runs 0..PRESCALE-1 and wraps.
  - On wrap, digit_idx increments, wrapping from NUM_DIGITS-1 to 0.
  - Frame length = NUM_DIGITS*PRESCALE clocks.
- Per-slot phases, with W = PRESCALE-BLANK_CYCLES and L = (brightness+1)*W/16:
  - BLANK: slot_cnt < BLANK_CYCLES.
  - ON: BLANK_CYCLES <= slot_cnt < BLANK_CYCLES+L.
  - OFF: remainder of the slot (empty when brightness=15).
- Outputs are registered with one-cycle latency from (digit_idx, slot_cnt):
  - ON phase with active digit_en[idx]=1: an_n = ~(1<<idx), seg_n = ~pattern(idx).
  - Otherwise: an_n = all 1, seg_n = all 1.
  - A disabled digit keeps its time slot, so brightness of the remaining digits is unchanged.
- Pattern:
  - Raw entry: data as stored.
  - Hex entry: standard hex table {0..9, A, b, C, d, E, F} for g..a, with dp = data[7].
- cur_digit = digit_idx, registered alongside an_n.
- frame_start is high for exactly one cycle: the cycle after the commit edge.

Decomposition:
- Package seg_scan_pkg holds:
  - segment bit positions (SEG_A..SEG_G, SEG_DP);
  - the all-off constant 8'hFF;
  - hex glyph constants;
  - the digit entry type {raw, data[7:0]}.
- One sub-module, hex_to_seg: purely combinational 4-bit nibble + dp -> active-high 8-bit pattern. It is instantiated once, after the active-entry mux.
- Counters, commit logic and output registers stay in the top module.

Test Plan (bench parameters: NUM_DIGITS=4, PRESCALE=40, BLANK_CYCLES=8, so W=32):
- Reset release:
  - Stimulus: hold reset 3 cycles, then release.
  - Required: an_n=4'hF and seg_n=8'hFF throughout. frame_start pulses at cycle 1 after release, then every 160 cycles.
- Hex write and commit:
  - Stimulus: write hex 0x3 to digit 1 and hex 0x0 with dp to digit 0, mid-frame; digit_en=4'hF; brightness=15.
  - Required: no change in the current frame. Next frame: digit 0 seg_n=8'h40 and digit 1 seg_n=8'hB0, each lit for 32 cycles after 8 blank cycles. an_n=4'hE and 4'hD respectively.
- Brightness:
  - Stimulus: brightness=7.
  - Required: 16 lit cycles per slot.
  - Stimulus: brightness=0.
  - Required: 2 lit cycles per slot, with the remainder dark.
  - Check: lit count measured per slot over 2 frames.
- Raw write and disable mask:
  - Stimulus: raw write 0x80 to digit 2; digit_en=4'b1011.
  - Required: digit 2's slot is fully dark with an_n=4'hF for 40 cycles. Digit 3 starts exactly at slot offset 120 from frame start.
- Commit collision and address range:
  - Stimulus: write digit 0 on the exact commit cycle; separately, write to wr_addr=5.
  - Required: the digit 0 update appears one frame later. The addr-5 write has no effect on any digit.
- Mid-slot reset:
  - Stimulus: assert reset during the ON phase of digit 2 for 1 cycle.
  - Required: next edge shows an_n=4'hF and cur_digit=0. All digits read blank after release until rewritten.
